// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
// Bundles the command handshake and the PS/2 pad-side signals of the
// host-to-device transmitter.
//   send, data_in            command strobe and byte to transmit
//   busy, done, error        transmitter status (done/error are 1-cycle pulses)
//   ps2_clk_in, ps2_dat_in   raw PS2_CLK / PS2_DAT pin levels
//   ps2_clk_oe, ps2_dat_oe   1 = pull the line low, 0 = release
// Modports:
//   master - controller and pad side (issues commands, supplies pin levels)
//   slave  - the transmitter itself
interface ps2_host_tx_if;
    logic       send;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output send, data_in, ps2_clk_in, ps2_dat_in,
        input  busy, done, error, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  send, data_in, ps2_clk_in, ps2_dat_in,
        output busy, done, error, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 command transmitter. Sends one byte using the
// inhibit / request-to-send / device-clocked shift / ACK sequence and
// drives the open-drain lines through output enables only; the tri-state
// buffers live in the top level.
// Ports:
//   clock   system clock
//   resetn  asynchronous active-low reset; releases both lines at once
//   bus     ps2_host_tx_if.slave (send, data_in, busy, done, error,
//           ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe)
// Parameters:
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before the start bit
//   RTS_CYCLES      cycles data is held low with clock low before release
//   TIMEOUT_CYCLES  watchdog limit between device edges / waiting for idle
// Configuration macro:
//   PS2_TX_TIMEOUT_EN  compiles in the watchdog; without it the FSM waits
//                      indefinitely and TIMEOUT_CYCLES is unused.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned RTS_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic         clock,
    input  logic         resetn,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Pin synchronisers and falling-edge detector
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic w_clk_fall;
    logic w_idle_lines;

    // Datapath registers
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_idx;
    logic [9:0]       r_shift;     // {stop, parity, d7..d0}
    logic             r_dat_oe;
    logic             r_done;
    logic             r_error;

    logic w_accept;
    logic w_timeout;
    logic w_clk_oe;
    logic w_dat_oe;
    logic w_busy;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= bus.ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_clk_fall   = r_clk_prev & ~r_clk_s2;
    assign w_idle_lines = r_clk_s2 & r_dat_s2;

    // A send in the same cycle as a done/error pulse is not accepted.
    assign w_accept = (r_state == S_IDLE) & bus.send & ~r_done & ~r_error;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_watched;

    assign w_watched = (r_state == S_SHIFT) | (r_state == S_ACK) | (r_state == S_WAIT_IDLE);

    // Cleared on every device clock edge and on every state entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if ((w_next != r_state) || w_clk_fall) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = w_watched & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) w_next = S_RTS;
            end
            S_RTS: begin
                if (r_cnt == CNT_W'(RTS_CYCLES - 1)) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_timeout)                             w_next = S_IDLE;
                else if (w_clk_fall && r_bit_idx == 4'd9)  w_next = S_ACK;
            end
            S_ACK: begin
                if (w_timeout)       w_next = S_IDLE;
                else if (w_clk_fall) w_next = r_dat_s2 ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_timeout || w_idle_lines) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: phase counter, shift register, registered data enable, pulses
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            // Pulses coincide with the return to IDLE, so busy drops in the same cycle.
            r_done  <= (r_state == S_WAIT_IDLE) & ~w_timeout & w_idle_lines;
            r_error <= w_timeout | ((r_state == S_ACK) & w_clk_fall & r_dat_s2);
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    r_dat_oe <= 1'b0;
                    if (w_accept) begin
                        r_shift   <= {1'b1, ~^bus.data_in, bus.data_in};
                        r_bit_idx <= '0;
                    end
                end
                S_RTS: begin
                    // Start bit stays driven into SHIFT until the first device edge.
                    r_dat_oe <= 1'b1;
                end
                S_SHIFT: begin
                    if (w_clk_fall) begin
                        r_dat_oe  <= ~r_shift[r_bit_idx];
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so that reset releases the lines immediately
    always_comb begin
        w_clk_oe = 1'b0;
        w_dat_oe = 1'b0;
        w_busy   = (r_state != S_IDLE);
        unique case (r_state)
            S_INHIBIT: begin
                w_clk_oe = 1'b1;
            end
            S_RTS: begin
                w_clk_oe = 1'b1;
                w_dat_oe = 1'b1;
            end
            S_SHIFT, S_ACK: begin
                w_dat_oe = r_dat_oe;
            end
            default: ;
        endcase
    end

    assign bus.ps2_clk_oe = w_clk_oe;
    assign bus.ps2_dat_oe = w_dat_oe;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the
// frame in, samples bits on rising edges and optionally ACKs. Expected bytes
// and outcomes are queued when a send is issued and compared once the device
// has captured the frame.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned RTS  = 5;
    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    // Open-drain wired-AND of host and device
    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
    } exp_t;

    exp_t sb[$];

    // Pulse monitor
    int  done_cnt   = 0;
    int  err_cnt    = 0;
    int  excl_viol  = 0;
    int  width_viol = 0;
    int  busy_viol  = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    always @(negedge clk) begin
        if (bus.done)  done_cnt++;
        if (bus.error) err_cnt++;
        if (bus.done && bus.error) excl_viol++;
        if ((bus.done && prev_done) || (bus.error && prev_err)) width_viol++;
        if ((bus.done || bus.error) && bus.busy) busy_viol++;
        prev_done = bus.done;
        prev_err  = bus.error;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        bus.data_in = d;
        bus.send    = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        chk("accept_busy", bus.busy, 1);
        chk("accept_clk_oe", bus.ps2_clk_oe, 1);
    endtask

    // Waits for RTS (both lines pulled) followed by clock release.
    task automatic wait_rts(output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.ps2_clk_oe && bus.ps2_dat_oe) seen = 1'b1;
            else if (seen && !bus.ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One device clock; the bit is sampled at the rising edge.
    task automatic dev_bit(output logic b);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        b = bus.ps2_dat_in;
        dev_clk_low = 1'b0;
    endtask

    // f[0]=start, f[8:1]=data, f[9]=parity, f[10]=stop
    task automatic dev_frame(input bit ack, output logic [10:0] f, output bit ok);
        f = '0;
        wait_rts(ok);
        if (!ok) return;
        f[0] = bus.ps2_dat_in;
        for (int i = 1; i <= 10; i++) begin
            logic b;
            dev_bit(b);
            f[i] = b;
        end
        repeat (HALF - 2) @(negedge clk);
        if (ack) dev_dat_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit inject,
                             input string tag, output logic [10:0] f);
        int   d0, e0;
        bit   ok, ok2;
        exp_t e;
        sb.push_back('{data: d, par: ~^d, ack: ack});
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(d);
        fork
            dev_frame(ack, f, ok);
            begin
                if (inject) begin
                    repeat (150) @(negedge clk);
                    chk({tag, "_busy_at_inject"}, bus.busy, 1);
                    bus.data_in = 8'h00;
                    bus.send    = 1'b1;
                    @(negedge clk);
                    bus.send    = 1'b0;
                end
            end
        join
        chk({tag, "_rts_seen"}, ok, 1);
        wait_not_busy(ok2);
        chk({tag, "_returns_idle"}, ok2, 1);
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        chk({tag, "_start"}, f[0], 0);
        chk({tag, "_data"}, f[8:1], e.data);
        chk({tag, "_parity"}, f[9], e.par);
        chk({tag, "_stop"}, f[10], 1);
        chk({tag, "_done_pulses"}, done_cnt - d0, e.ack ? 1 : 0);
        chk({tag, "_error_pulses"}, err_cnt - e0, e.ack ? 0 : 1);
        chk({tag, "_clk_oe_released"}, bus.ps2_clk_oe, 0);
        chk({tag, "_dat_oe_released"}, bus.ps2_dat_oe, 0);
    endtask

    initial begin
        logic [10:0] f;
        bit          ok;
        int          n, e0;
        bus.send    = 1'b0;
        bus.data_in = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_dat_oe", bus.ps2_dat_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Normal commands
        run_frame(8'hF4, 1'b1, 1'b0, "f4", f);
        chk("f4_parity_zero", f[9], 0);
        chk("f4_bits", f[8:1], 32'hF4);
        run_frame(8'hFF, 1'b1, 1'b0, "ff", f);
        chk("ff_parity_one", f[9], 1);

        // Missing ACK
        run_frame(8'h3C, 1'b0, 1'b0, "noack", f);

        // Device never clocks after RTS
        e0 = err_cnt;
        send_byte(8'h55);
        wait_rts(ok);
        chk("to_rts_seen", ok, 1);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 2 * TO; i++) begin
            @(negedge clk);
            n++;
            if (bus.error) break;
        end
        chk("to_cycles", n, TO);
        chk("to_busy_low", bus.busy, 0);
        chk("to_clk_oe", bus.ps2_clk_oe, 0);
        chk("to_dat_oe", bus.ps2_dat_oe, 0);
        repeat (2) @(negedge clk);
        chk("to_error_pulses", err_cnt - e0, 1);
`else
        n = 0;
        repeat (2 * TO) @(negedge clk);
        chk("noto_busy_held", bus.busy, 1);
        chk("noto_no_error", err_cnt - e0, n);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // send re-asserted mid-frame is ignored, nothing queued
        run_frame(8'hA5, 1'b1, 1'b1, "inject", f);
        repeat (50) @(negedge clk);
        chk("inject_not_queued", bus.busy, 0);

        // Reset in the middle of the fifth device clock
        send_byte(8'h00);
        wait_rts(ok);
        chk("mid_rts_seen", ok, 1);
        for (int i = 0; i < 4; i++) begin
            logic b;
            dev_bit(b);
        end
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_pre_dat_oe", bus.ps2_dat_oe, 1);
        chk("mid_pre_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_oe", bus.ps2_clk_oe, 0);
        chk("mid_rst_dat_oe", bus.ps2_dat_oe, 0);
        chk("mid_rst_busy", bus.busy, 0);
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(8'hF4, 1'b1, 1'b0, "after_rst", f);

        chk("done_error_exclusive", excl_viol, 0);
        chk("pulse_width_one", width_viol, 0);
        chk("busy_low_with_pulse", busy_viol, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter: the write direction of the PS/2 link whose read side feeds the mouse tracker. It sends one byte (e.g. 0xF4 enable reporting, 0xFF reset) using the standard inhibit, request-to-send, device-clocked shift and ACK sequence. It drives the shared open-drain PS2_CLK/PS2_DAT lines through output-enable pins, and the top level owns the tri-state buffers. Intended use is mouse initialisation before the tracker starts decoding packets.

## Interface
- INHIBIT_CYCLES, 6000: clock cycles that PS2_CLK is held low before the start bit (120 µs at 50 MHz).
- RTS_CYCLES, 100: cycles that data is held low with clock still low before clock is released.
- TIMEOUT_CYCLES, 750000: maximum cycles between device clock falling edges, or while waiting for idle (15 ms).
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous, active-low reset.
- send  in  1  start-transmission strobe; sampled only in IDLE.
- data_in  in  8  byte to send; latched on the accepted send.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  high from the cycle after send is accepted until return to IDLE.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- error  out  1  one-cycle pulse: no ACK, or timeout.

## Operation
- Inputs ps2_clk_in/ps2_dat_in pass through 2-flop synchronisers. A falling edge is sync-clk 1→0 (registered previous value).
- Frame: start(0), d0..d7 LSB first, odd parity (~^data), stop(1, released), then device ACK.
- States:
  - IDLE: lines released. send=1 → latch data_in and parity, counter=0 → INHIBIT.
  - INHIBIT: clk_oe=1. Counter reaches INHIBIT_CYCLES-1 → RTS.
  - RTS: clk_oe=1, dat_oe=1 (start bit). After RTS_CYCLES → SHIFT with clk_oe=0 and bit index=0.
  - SHIFT: on each falling edge, present the next bit: dat_oe = ~bit. Edges 1–8 carry d0..d7, edge 9 carries parity, edge 10 releases data (stop). After edge 10 → ACK.
  - ACK: on edge 11, sample sync data. 0 → WAIT_IDLE. 1 → pulse error → IDLE.
  - WAIT_IDLE: wait for sync clk=1 and sync data=1, then pulse done → IDLE.
- The timeout counter clears on every falling edge and on every state entry. In SHIFT, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines, pulses error, and returns to IDLE.
- send during busy is ignored. No queueing.
- Odd parity: data 0xF4 gives parity 0; data 0xFF gives parity 1.

## Timing
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, state IDLE. Reset mid-frame releases both lines asynchronously.
- busy rises 1 cycle after send is accepted.
- ps2_clk_oe rises 1 cycle after send is accepted.
- Edge detection lags the pin by 3 cycles (2 sync stages plus the edge register). dat_oe updates 1 cycle after detection, i.e. well inside the device's clock-low half-period.
- done and error are mutually exclusive. Each is exactly 1 cycle wide, and busy falls in the same cycle.
- A new send is accepted no earlier than the cycle after done/error.
- Minimum frame: INHIBIT_CYCLES + RTS_CYCLES + 11 device clocks + idle wait.

## Configuration
- PS2_TX_TIMEOUT_EN defined: the timeout watchdog above is compiled in.
- PS2_TX_TIMEOUT_EN undefined: no watchdog and no timeout counter. The FSM waits indefinitely for device edges and idle lines, and error fires only on a missing ACK. TIMEOUT_CYCLES is then unused.

## Test plan
- Send 0xF4 (INHIBIT_CYCLES=20, RTS_CYCLES=5) with a device model clocking at 10 kHz-equivalent and ACKing → bits sampled on rising edges are 0,0,0,1,0,1,1,1,1, parity 0, stop 1. One done pulse, no error, busy low afterward.
- Send 0xFF → parity bit 1 is sampled, done pulses.
- Device leaves data high on edge 11 (no ACK) → one error pulse, both oe=0, IDLE.
- Device never clocks after RTS, with the macro defined and TIMEOUT_CYCLES=200 → error exactly when the counter reaches 200 after RTS exit. With the macro undefined, busy stays high.
- send re-asserted during SHIFT with data 0x00 → ignored, and the original byte completes unchanged.
- resetn low during SHIFT edge 5 → oe outputs 0 immediately and busy=0. A subsequent send 0xF4 completes normally.
